// File: rtl/wide_add_seq.sv
// Multi-word add/subtract that pushes WORDS slices of WIDTH bits through one
// shared WIDTH-bit adder, LSB slice first, one slice per clock.
module wide_add_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         carry_q, carry_d;
  logic [WORDS-1:0][WIDTH-1:0]  a_q, a_d;
  logic [WORDS-1:0][WIDTH-1:0]  b_q, b_d;
  logic [WORDS-1:0][WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH*WORDS-1:0]       sum_q, sum_d;
  logic                         cout_q, cout_d;
  logic [WIDTH:0]               slice_res;

  // The one and only adder: a WIDTH-bit slice plus the running carry.
  assign slice_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{WIDTH{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          // Subtraction is a + ~b + 1, so invert b and force the carry-in.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q] = slice_res[WIDTH-1:0];
        carry_d      = slice_res[WIDTH];
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = slice_res[WIDTH];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq (WIDTH=32, WORDS=4): directed vector table, start-while-busy,
// mid-run reset and a seeded random run against a 129-bit arithmetic model.
module tb_wide_add_seq;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;
  localparam int unsigned T = W * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [T-1:0] a;
  logic [T-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [T-1:0] sum;
  logic         cout;

  int tests;
  int failed;

  wide_add_seq #(.WIDTH(W), .WORDS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [T-1:0] va;
    logic [T-1:0] vb;
    logic         vcin;
    logic         vsub;
    logic [T-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[7];

  // Plain arithmetic reference: 129-bit add, or a-b with "no borrow" as carry.
  function automatic logic [T:0] model(input logic [T-1:0] ma, input logic [T-1:0] mb,
                                       input logic mcin, input logic msub);
    logic [T:0] r;
    if (msub) begin
      r[T-1:0] = ma - mb;
      r[T]     = (ma >= mb);
    end else begin
      r = {1'b0, ma} + {1'b0, mb} + {{T{1'b0}}, mcin};
    end
    return r;
  endfunction

  task automatic chk_wide(input string name, input logic [T-1:0] got, input logic [T-1:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the DONE->IDLE edge.
  task automatic run_op(input logic [T-1:0] ta, input logic [T-1:0] tbv, input logic tcin,
                        input logic tsub, output logic [T-1:0] rs, output logic rc,
                        output int lat, output logic [T-1:0] held, output logic bsy);
    a     = ta;
    b     = tbv;
    cin   = tcin;
    sub   = tsub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    held  = sum;
    bsy   = busy;
    lat   = -1;
    rs    = '0;
    rc    = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    rs = sum;
    rc = cout;
    @(posedge clk);
    #1;
  endtask

  logic [T-1:0] prev_sum;
  logic [T-1:0] rs;
  logic [T-1:0] held;
  logic [T:0]   m;
  logic         rc;
  logic         bsy;
  int           lat;
  int           dones;
  int           rand_err;

  function automatic logic [W-1:0] rand_word();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return $urandom();
  endfunction

  initial begin
    tests    = 0;
    failed   = 0;
    rand_err = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    cin      = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{"ripple", '1, '0, 1'b1, 1'b0, '0, 1'b1};
    vecs[1] = '{"slice_boundary", 128'h1_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 128'h2_0000_0000, 1'b0};
    vecs[2] = '{"sub_5_7", 128'd5, 128'd7, 1'b0, 1'b1,
                {{3{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}, 1'b0};
    vecs[3] = '{"sub_7_5", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1};
    vecs[4] = '{"sub_0_0", '0, '0, 1'b0, 1'b1, '0, 1'b1};
    vecs[5] = '{"max_plus_max", '1, '1, 1'b1, 1'b0, '1, 1'b1};
    vecs[6] = '{"sub_ignores_cin", 128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1};

    #1;
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk_wide("reset_sum", sum, '0);
    chk_int("reset_cout", int'(cout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    prev_sum = '0;
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, rs, rc, lat, held, bsy);
      chk_wide({vecs[i].name, "_sum"}, rs, vecs[i].exp_sum);
      chk_int({vecs[i].name, "_cout"}, int'(rc), int'(vecs[i].exp_cout));
      chk_int({vecs[i].name, "_latency"}, lat, N);
      chk_int({vecs[i].name, "_busy"}, int'(bsy), 1);
      chk_wide({vecs[i].name, "_sum_held"}, held, prev_sum);
      prev_sum = vecs[i].exp_sum;
    end

    // start held high with changing operands while busy; then re-accepted after done.
    a     = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    b     = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a     = 128'hDEAD_BEEF;
    b     = '1;
    sub   = 1'b1;
    cin   = 1'b1;
    dones = 0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        lat = i;
        break;
      end
    end
    chk_int("hold_start_latency", lat, N);
    chk_wide("hold_start_sum", sum, 128'h1234_5678_ABCD_F011_3344_5566_8899_AABB);
    chk_int("hold_start_cout", int'(cout), 0);
    a   = 128'd100;
    b   = 128'd1;
    sub = 1'b1;
    @(posedge clk);
    #1;
    chk_int("hold_start_single_done", int'(done), 0);
    chk_int("hold_start_idle", int'(busy), 0);
    @(posedge clk);
    #1;
    chk_int("back_to_back_accept", int'(busy), 1);
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk_int("back_to_back_latency", lat, N);
    chk_wide("back_to_back_sum", sum, 128'd99);
    chk_int("back_to_back_cout", int'(cout), 1);
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle.
    a     = 128'd40;
    b     = 128'd2;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_int("midrun_reset_busy", int'(busy), 0);
    chk_wide("midrun_reset_sum", sum, '0);
    chk_int("midrun_reset_cout", int'(cout), 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (i == 1) rst_n = 1'b1;
    end
    chk_int("midrun_reset_no_done", dones, 0);
    run_op(128'd40, 128'd2, 1'b1, 1'b0, rs, rc, lat, held, bsy);
    chk_wide("after_reset_sum", rs, 128'd43);
    chk_int("after_reset_cout", int'(rc), 0);
    chk_int("after_reset_latency", lat, N);

    // Seeded random run against the arithmetic model.
    void'($urandom(32'd20240611));
    for (int i = 0; i < 10000; i++) begin
      logic [T-1:0] ra;
      logic [T-1:0] rb;
      logic         rcin;
      logic         rsub;
      ra   = {rand_word(), rand_word(), rand_word(), rand_word()};
      rb   = {rand_word(), rand_word(), rand_word(), rand_word()};
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      m    = model(ra, rb, rcin, rsub);
      run_op(ra, rb, rcin, rsub, rs, rc, lat, held, bsy);
      tests++;
      if (rs !== m[T-1:0]) begin
        failed++;
        rand_err++;
        $display("FAIL rand_sum[%0d]: got %h expected %h", i, rs, m[T-1:0]);
      end
      tests++;
      if (rc !== m[T]) begin
        failed++;
        rand_err++;
        $display("FAIL rand_cout[%0d]: got %0b expected %0b", i, rc, m[T]);
      end
      tests++;
      if (lat != N) begin
        failed++;
        rand_err++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, N);
      end
    end
    if (rand_err == 0) $display("[TB] random vectors PASSED");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
